// File: rtl/lc3_pkg.sv
// Shared constants and types for the LC-3 device-register responder.
// Bit 14 of KBSR/DSR (IE) only has meaning when LC3_MMIO_IRQ_EN is defined.
package lc3_pkg;

    localparam logic [15:0] LC3_KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] LC3_KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] LC3_DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] LC3_DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] LC3_MCR_ADDR  = 16'hFFFE;

    localparam int READY = 15;
    localparam int IE    = 14;
    localparam int OVR   = 13;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_KBSR,
        SEL_KBDR,
        SEL_DSR,
        SEL_DDR,
        SEL_MCR
    } reg_sel_e;

    // Captured access; the decoded select stands in for the raw address.
    typedef struct packed {
        logic        we;
        reg_sel_e    sel;
        logic [15:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/lc3_mmio_responder_if.sv
// Core-to-device-register bus: request side from the core, response side from the responder.
interface lc3_mmio_responder_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        hit;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, we, addr, wdata, input hit, ack, rdata);
    modport slave  (input req, we, addr, wdata, output hit, ack, rdata);
endinterface

// File: rtl/lc3_disp_chan.sv
// Display output channel: one-character holding register with valid/ready handshake.
// DSR ready is simply "no character pending".
module lc3_disp_chan (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ddr_wr,
    input  logic [7:0] wr_byte,
    input  logic       disp_ready,
    output logic       disp_valid,
    output logic [7:0] disp_data,
    output logic       dsr_ready
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else if (disp_valid) begin
            if (disp_ready)
                disp_valid <= 1'b0;
        end else if (ddr_wr) begin
            disp_valid <= 1'b1;
            disp_data  <= wr_byte;
        end
    end

    assign dsr_ready = ~disp_valid;

endmodule

// File: rtl/lc3_mmio_responder.sv
// LC-3 device-register target: KBSR/KBDR, DSR/DDR and MCR behind a two-state bus FSM.
// Optional macro LC3_MMIO_IRQ_EN adds KBSR/DSR interrupt-enable bits and a registered irq output.
//
// state   | meaning
// IDLE    | waiting for req & hit; captures the access
// RESP    | ack high for one cycle, read data driven, side-effects applied
module lc3_mmio_responder
    import lc3_pkg::*;
#(
    parameter logic [15:0] KBSR_ADDR = LC3_KBSR_ADDR,
    parameter logic [15:0] KBDR_ADDR = LC3_KBDR_ADDR,
    parameter logic [15:0] DSR_ADDR  = LC3_DSR_ADDR,
    parameter logic [15:0] DDR_ADDR  = LC3_DDR_ADDR,
    parameter logic [15:0] MCR_ADDR  = LC3_MCR_ADDR
) (
    input  logic                 CLK,
    input  logic                 RST,
    lc3_mmio_responder_if.slave  bus,
    input  logic                 key_valid,
    input  logic [7:0]           key_data,
    output logic                 disp_valid,
    output logic [7:0]           disp_data,
    input  logic                 disp_ready,
    output logic                 run
`ifdef LC3_MMIO_IRQ_EN
    ,
    output logic                 irq
`endif
);

    function automatic reg_sel_e decode(input logic [15:0] a);
        if (a == KBSR_ADDR) return SEL_KBSR;
        if (a == KBDR_ADDR) return SEL_KBDR;
        if (a == DSR_ADDR)  return SEL_DSR;
        if (a == DDR_ADDR)  return SEL_DDR;
        if (a == MCR_ADDR)  return SEL_MCR;
        return SEL_NONE;
    endfunction

    reg_sel_e   sel_in;
    logic [0:0] state;
    bus_req_t   req_q;

    assign sel_in  = decode(bus.addr);
    assign bus.hit = (sel_in != SEL_NONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            req_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req && bus.hit) begin
                        state       <= ST_RESP;
                        req_q.we    <= bus.we;
                        req_q.sel   <= sel_in;
                        req_q.wdata <= bus.wdata;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic rd_stb, wr_stb;
    logic kbdr_rd, kbsr_wr, ddr_wr, mcr_wr;

    assign bus.ack = (state == ST_RESP);
    assign rd_stb  = bus.ack && !req_q.we;
    assign wr_stb  = bus.ack &&  req_q.we;
    assign kbdr_rd = rd_stb && (req_q.sel == SEL_KBDR);
    assign kbsr_wr = wr_stb && (req_q.sel == SEL_KBSR);
    assign ddr_wr  = wr_stb && (req_q.sel == SEL_DDR);
    assign mcr_wr  = wr_stb && (req_q.sel == SEL_MCR);

    logic       kb_ready, kb_ovr;
    logic [7:0] kbdr;

    // A key arriving in the KBDR-read ack cycle replaces the one being consumed, so it is not an overrun.
    always_ff @(posedge CLK) begin
        if (RST) begin
            kb_ready <= 1'b0;
            kb_ovr   <= 1'b0;
            kbdr     <= 8'h00;
        end else begin
            if (key_valid && kb_ready && !kbdr_rd)
                kb_ovr <= 1'b1;
            else if (kbsr_wr && !req_q.wdata[OVR])
                kb_ovr <= 1'b0;

            if (key_valid && (!kb_ready || kbdr_rd)) begin
                kbdr     <= key_data;
                kb_ready <= 1'b1;
            end else if (kbdr_rd) begin
                kb_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            run <= 1'b1;
        else if (mcr_wr)
            run <= req_q.wdata[READY];
    end

    logic dsr_ready;

    lc3_disp_chan u_disp_chan (
        .CLK        (CLK),
        .RST        (RST),
        .ddr_wr     (ddr_wr),
        .wr_byte    (req_q.wdata[7:0]),
        .disp_ready (disp_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .dsr_ready  (dsr_ready)
    );

    logic kb_ie, dsr_ie;

`ifdef LC3_MMIO_IRQ_EN
    logic dsr_wr;
    assign dsr_wr = wr_stb && (req_q.sel == SEL_DSR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            kb_ie  <= 1'b0;
            dsr_ie <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (kbsr_wr) kb_ie  <= req_q.wdata[IE];
            if (dsr_wr)  dsr_ie <= req_q.wdata[IE];
            irq <= (kb_ready & kb_ie) | (dsr_ready & dsr_ie);
        end
    end
`else
    assign kb_ie  = 1'b0;
    assign dsr_ie = 1'b0;
    logic unused_ie_bit;
    assign unused_ie_bit = req_q.wdata[IE];
`endif

    logic unused_wdata_bits;
    assign unused_wdata_bits = &{1'b0, req_q.wdata[12:8]};

    always_comb begin
        bus.rdata = 16'h0000;
        if (rd_stb) begin
            case (req_q.sel)
                SEL_KBSR: bus.rdata = {kb_ready, kb_ie, kb_ovr, 13'b0};
                SEL_KBDR: bus.rdata = {8'h00, kbdr};
                SEL_DSR:  bus.rdata = {dsr_ready, dsr_ie, 14'b0};
                SEL_MCR:  bus.rdata = {run, 15'b0};
                default:  bus.rdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mmio_responder.sv
// Self-checking bench for lc3_mmio_responder: directed scenarios plus randomized traffic
// against a register-level reference model. Inputs change and outputs are sampled on negedge.
module tb_lc3_mmio_responder;
    import lc3_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       key_valid;
    logic [7:0] key_data;
    logic       disp_valid;
    logic [7:0] disp_data;
    logic       disp_ready;
    logic       run;
`ifdef LC3_MMIO_IRQ_EN
    logic       irq;
`endif

    always #5 CLK = ~CLK;

    lc3_mmio_responder_if bus ();

    lc3_mmio_responder dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .run        (run)
`ifdef LC3_MMIO_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model of the software-visible registers.
    logic       m_ready, m_ovr, m_pending, m_run, m_kie, m_die;
    logic [7:0] m_kbdr, m_disp;

    task automatic model_reset();
        m_ready = 0; m_ovr = 0; m_kbdr = 8'h00;
        m_pending = 0; m_disp = 8'h00; m_run = 1;
        m_kie = 0; m_die = 0;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        case (a)
            LC3_KBSR_ADDR: return {m_ready, m_kie, m_ovr, 13'b0};
            LC3_KBDR_ADDR: return {8'h00, m_kbdr};
            LC3_DSR_ADDR:  return {~m_pending, m_die, 14'b0};
            LC3_MCR_ADDR:  return {m_run, 15'b0};
            default:       return 16'h0000;
        endcase
    endfunction

    function automatic logic is_reg(input logic [15:0] a);
        return (a == LC3_KBSR_ADDR) || (a == LC3_KBDR_ADDR) || (a == LC3_DSR_ADDR) ||
               (a == LC3_DDR_ADDR) || (a == LC3_MCR_ADDR);
    endfunction

    task automatic model_access(input logic w, input logic [15:0] a, input logic [15:0] d);
        if (!w) begin
            if (a == LC3_KBDR_ADDR) m_ready = 0;
        end else begin
            case (a)
                LC3_KBSR_ADDR: begin
                    if (!d[13]) m_ovr = 0;
`ifdef LC3_MMIO_IRQ_EN
                    m_kie = d[14];
`endif
                end
                LC3_DSR_ADDR: begin
`ifdef LC3_MMIO_IRQ_EN
                    m_die = d[14];
`endif
                end
                LC3_DDR_ADDR: if (!m_pending) begin m_pending = 1; m_disp = d[7:0]; end
                LC3_MCR_ADDR: m_run = d[15];
                default: ;
            endcase
        end
    endtask

    // One bus access starting at a negedge; returns at the negedge after the ack cycle.
    // exp_rd < 0 means take the expected read value from the model.
    task automatic bus_access(input string name, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input int exp_rd);
        logic [15:0] e;
        logic        exp_hit;
        int          lat;
        exp_hit = is_reg(a);
        e = (exp_rd >= 0) ? exp_rd[15:0] : model_read(a);
        bus.req = 1; bus.we = w; bus.addr = a; bus.wdata = d;
        #1;
        vectors++;
        if (bus.hit !== exp_hit) begin
            miscompares++;
            $display("FAIL %s hit: got %b want %b", name, bus.hit, exp_hit);
        end
        lat = 0;
        for (int i = 1; i <= 3 && lat == 0; i++) begin
            @(negedge CLK);
            if (bus.ack === 1'b1) begin
                lat = i;
                if (!w) begin
                    vectors++;
                    if (bus.rdata !== e) begin
                        miscompares++;
                        $display("FAIL %s rdata: got %h want %h", name, bus.rdata, e);
                    end
                end
            end
        end
        bus.req = 0; bus.we = 0; bus.wdata = 16'h0000;
        vectors++;
        if (lat != (exp_hit ? 1 : 0)) begin
            miscompares++;
            $display("FAIL %s ack latency: got %0d want %0d", name, lat, exp_hit ? 1 : 0);
        end
        @(negedge CLK);
        vectors++;
        if (bus.ack !== 1'b0 || bus.rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL %s post-ack: got ack=%b rdata=%h want ack=0 rdata=0000", name, bus.ack, bus.rdata);
        end
        if (exp_hit) model_access(w, a, d);
    endtask

    task automatic key_pulse(input logic [7:0] k);
        key_valid = 1; key_data = k;
        @(negedge CLK);
        key_valid = 0;
        if (!m_ready) begin m_ready = 1; m_kbdr = k; end
        else m_ovr = 1;
    endtask

    task automatic test_reset();
        RST = 1;
        bus.req = 0; bus.we = 0; bus.addr = 16'h0000; bus.wdata = 16'h0000;
        key_valid = 0; key_data = 8'h00; disp_ready = 0;
        repeat (2) @(negedge CLK);
        vectors++;
        if (bus.ack !== 1'b0 || bus.rdata !== 16'h0000 || disp_valid !== 1'b0 ||
            disp_data !== 8'h00 || run !== 1'b1) begin
            miscompares++;
            $display("FAIL reset outputs: got ack=%b rdata=%h dv=%b dd=%h run=%b want 0 0000 0 00 1",
                     bus.ack, bus.rdata, disp_valid, disp_data, run);
        end
        RST = 0;
        model_reset();
        bus_access("rst_dsr",  0, LC3_DSR_ADDR,  16'h0, 'h8000);
        bus_access("rst_kbsr", 0, LC3_KBSR_ADDR, 16'h0, 'h0000);
        bus_access("rst_kbdr", 0, LC3_KBDR_ADDR, 16'h0, 'h0000);
        bus_access("rst_mcr",  0, LC3_MCR_ADDR,  16'h0, 'h8000);
    endtask

    task automatic test_keyboard();
        key_pulse(8'h41);
        bus_access("kb_kbsr1", 0, LC3_KBSR_ADDR, 16'h0, 'h8000);
        bus_access("kb_kbdr",  0, LC3_KBDR_ADDR, 16'h0, 'h0041);
        bus_access("kb_kbsr2", 0, LC3_KBSR_ADDR, 16'h0, 'h0000);
    endtask

    task automatic test_overrun();
        key_pulse(8'h41);
        key_pulse(8'h42);
        bus_access("ovr_kbsr",  0, LC3_KBSR_ADDR, 16'h0,    'hA000);
        bus_access("ovr_clr",   1, LC3_KBSR_ADDR, 16'h0000, -1);
        bus_access("ovr_kbsr2", 0, LC3_KBSR_ADDR, 16'h0,    'h8000);
        bus_access("ovr_kbdr",  0, LC3_KBDR_ADDR, 16'h0,    'h0041);
        bus_access("ovr_kbsr3", 0, LC3_KBSR_ADDR, 16'h0,    'h0000);
    endtask

    task automatic test_display();
        disp_ready = 0;
        bus_access("disp_wr1", 1, LC3_DDR_ADDR, 16'h0058, -1);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (disp_valid !== 1'b1 || disp_data !== 8'h58) begin
                miscompares++;
                $display("FAIL disp_hold: got dv=%b dd=%h want 1 58", disp_valid, disp_data);
            end
            @(negedge CLK);
        end
        bus_access("disp_wr2", 1, LC3_DDR_ADDR, 16'h0059, -1);
        vectors++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h58) begin
            miscompares++;
            $display("FAIL disp_drop: got dv=%b dd=%h want 1 58", disp_valid, disp_data);
        end
        bus_access("disp_dsr0", 0, LC3_DSR_ADDR, 16'h0, 'h0000);
        bus_access("disp_ddr_rd", 0, LC3_DDR_ADDR, 16'h0, 'h0000);
        disp_ready = 1;
        @(negedge CLK);
        disp_ready = 0;
        m_pending = 0;
        vectors++;
        if (disp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL disp_accept: got dv=%b want 0", disp_valid);
        end
        bus_access("disp_dsr1", 0, LC3_DSR_ADDR, 16'h0, 'h8000);
    endtask

    task automatic test_mcr_reset();
        bus_access("mcr_wr0", 1, LC3_MCR_ADDR, 16'h0000, -1);
        vectors++;
        if (run !== 1'b0) begin
            miscompares++;
            $display("FAIL mcr_run: got %b want 0", run);
        end
        bus_access("mcr_rd", 0, LC3_MCR_ADDR, 16'h0, 'h0000);
        key_pulse(8'h33);
        bus_access("mcr_ddr", 1, LC3_DDR_ADDR, 16'h0021, -1);
        // Reset together with a request: the access must be dropped.
        bus.req = 1; bus.we = 0; bus.addr = LC3_KBDR_ADDR; RST = 1;
        @(negedge CLK);
        vectors++;
        if (bus.ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_drop ack: got %b want 0", bus.ack);
        end
        bus.req = 0; RST = 0;
        model_reset();
        @(negedge CLK);
        vectors++;
        if (bus.ack !== 1'b0 || run !== 1'b1 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_state: got ack=%b run=%b dv=%b dd=%h want 0 1 0 00",
                     bus.ack, run, disp_valid, disp_data);
        end
        bus_access("rst2_kbsr", 0, LC3_KBSR_ADDR, 16'h0, 'h0000);
        bus_access("rst2_kbdr", 0, LC3_KBDR_ADDR, 16'h0, 'h0000);
        bus_access("rst2_dsr",  0, LC3_DSR_ADDR,  16'h0, 'h8000);
    endtask

    task automatic test_miss_and_race();
        bus_access("miss", 0, 16'h0200, 16'h0, -1);
        key_pulse(8'h11);
        bus.req = 1; bus.we = 0; bus.addr = LC3_KBDR_ADDR;
        @(negedge CLK);
        vectors++;
        if (bus.ack !== 1'b1 || bus.rdata !== 16'h0011) begin
            miscompares++;
            $display("FAIL race ack: got ack=%b rdata=%h want 1 0011", bus.ack, bus.rdata);
        end
        bus.req = 0;
        key_valid = 1; key_data = 8'h5A;
        @(negedge CLK);
        key_valid = 0;
        m_ready = 1; m_kbdr = 8'h5A;
        bus_access("race_kbsr",  0, LC3_KBSR_ADDR, 16'h0, 'h8000);
        bus_access("race_kbdr",  0, LC3_KBDR_ADDR, 16'h0, 'h005A);
        bus_access("race_kbsr2", 0, LC3_KBSR_ADDR, 16'h0, 'h0000);
    endtask

    task automatic test_random();
        logic [15:0] addrs [5];
        logic [15:0] a, d;
        logic        w;
        int          op;
        addrs[0] = LC3_KBSR_ADDR; addrs[1] = LC3_KBDR_ADDR; addrs[2] = LC3_DSR_ADDR;
        addrs[3] = LC3_DDR_ADDR;  addrs[4] = LC3_MCR_ADDR;
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 7));
            if (op <= 1) begin
                key_pulse(8'($urandom));
            end else if (op == 2) begin
                disp_ready = 1;
                @(negedge CLK);
                disp_ready = 0;
                m_pending = 0;
            end else begin
                if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(0, 16'h3FFF));
                else a = addrs[$urandom_range(0, 4)];
                w = 1'($urandom);
                d = 16'($urandom);
                bus_access("rand", w, a, d, -1);
            end
            vectors++;
            if (disp_valid !== m_pending || (m_pending && disp_data !== m_disp) || run !== m_run) begin
                miscompares++;
                $display("FAIL rand outputs: got dv=%b dd=%h run=%b want dv=%b dd=%h run=%b",
                         disp_valid, disp_data, run, m_pending, m_disp, m_run);
            end
`ifdef LC3_MMIO_IRQ_EN
            @(negedge CLK);
            vectors++;
            if (irq !== ((m_ready & m_kie) | (~m_pending & m_die))) begin
                miscompares++;
                $display("FAIL rand irq: got %b want %b", irq, (m_ready & m_kie) | (~m_pending & m_die));
            end
`endif
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_keyboard();
        test_overrun();
        test_display();
        test_mcr_reset();
        test_miss_and_race();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
